// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter : shares one single-port RAM between three readers and one
//                    writer using a rotating-priority grant.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter  int AXI_WIDTH      = 128,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int WR_PRIORITY    = 0,
  localparam int LSB            = $clog2(AXI_WIDTH) - 3,
  localparam int AW             = AXI_ADDR_WIDTH - LSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               rd_valid,
  input  logic [3*AW-1:0]          rd_addr,
  output logic [2:0]               rd_ready,
  output logic [3*AXI_WIDTH-1:0]   rd_data,
  output logic [2:0]               rd_rvalid,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [AXI_WIDTH-1:0]     wr_data,
  input  logic [AXI_WIDTH/8-1:0]   wr_strb,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [AW-1:0]            mem_addr,
  output logic [AXI_WIDTH-1:0]     mem_wdata,
  output logic [AXI_WIDTH/8-1:0]   mem_strb,
  input  logic [AXI_WIDTH-1:0]     mem_rdata
);

  localparam logic [1:0] c_WR_IDX = 2'd3;

  logic [1:0]                 r_ptr;
  logic                       r_pending;
  logic [1:0]                 r_tag;
  logic [3*AXI_WIDTH-1:0]     r_rd_data;
  logic [2:0]                 r_rd_rvalid;

  logic [3:0] w_req;
  logic       w_gnt;
  logic [1:0] w_gidx;
  logic       w_rd_gnt;
  logic       w_wr_gnt;

  assign w_req = {wr_valid, rd_valid};

  // Scan from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = 2'd0;
    if (!rst) begin
      if (WR_PRIORITY != 0 && wr_valid) begin
        w_gnt  = 1'b1;
        w_gidx = c_WR_IDX;
      end else begin
        for (int k = 3; k >= 0; k--) begin
          if (w_req[r_ptr + 2'(k)]) begin
            w_gnt  = 1'b1;
            w_gidx = r_ptr + 2'(k);
          end
        end
      end
    end
  end

  assign w_rd_gnt = w_gnt && (w_gidx != c_WR_IDX);
  assign w_wr_gnt = w_gnt && (w_gidx == c_WR_IDX);

  always_comb begin
    rd_ready = 3'b000;
    mem_addr = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_rd_gnt && w_gidx == 2'(i)) begin
        rd_ready[i] = 1'b1;
        mem_addr    = rd_addr[i*AW +: AW];
      end
    end
    if (w_wr_gnt) begin
      mem_addr = wr_addr;
    end
  end

  assign wr_ready  = w_wr_gnt;
  assign mem_ren   = w_rd_gnt;
  assign mem_wen   = w_wr_gnt;
  assign mem_wdata = w_wr_gnt ? wr_data : '0;
  assign mem_strb  = w_wr_gnt ? wr_strb : '0;

  // RAM data arrives the cycle after mem_ren; r_tag remembers whose it is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_pending   <= 1'b0;
      r_tag       <= 2'd0;
      r_rd_data   <= '0;
      r_rd_rvalid <= 3'b000;
    end else begin
      r_rd_rvalid <= 3'b000;
      if (r_pending) begin
        for (int i = 0; i < 3; i++) begin
          if (r_tag == 2'(i)) begin
            r_rd_data[i*AXI_WIDTH +: AXI_WIDTH] <= mem_rdata;
            r_rd_rvalid[i]                      <= 1'b1;
          end
        end
      end
      r_pending <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_tag <= w_gidx;
      end
      if (w_rd_gnt || (w_wr_gnt && WR_PRIORITY == 0)) begin
        r_ptr <= w_gidx + 2'd1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_rvalid = r_rd_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter : directed self-checking bench for ram_port_arbiter.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AXI_WIDTH      = 128;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AW             = 28;
  localparam int SW             = AXI_WIDTH / 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [2:0]              rd_valid;
  logic [3*AW-1:0]         rd_addr;
  logic [2:0]              rd_ready;
  logic [3*AXI_WIDTH-1:0]  rd_data;
  logic [2:0]              rd_rvalid;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [AXI_WIDTH-1:0]    wr_data;
  logic [SW-1:0]           wr_strb;
  logic                    mem_ren;
  logic                    mem_wen;
  logic [AW-1:0]           mem_addr;
  logic [AXI_WIDTH-1:0]    mem_wdata;
  logic [SW-1:0]           mem_strb;
  logic [AXI_WIDTH-1:0]    mem_rdata;

  logic [2:0]              p_rd_valid;
  logic                    p_wr_valid;
  logic [2:0]              p_rd_ready;
  logic                    p_wr_ready;
  logic [3*AXI_WIDTH-1:0]  p_rd_data;
  logic [2:0]              p_rd_rvalid;
  logic                    p_mem_ren;
  logic                    p_mem_wen;
  logic [AW-1:0]           p_mem_addr;
  logic [AXI_WIDTH-1:0]    p_mem_wdata;
  logic [SW-1:0]           p_mem_strb;
  logic [AXI_WIDTH-1:0]    p_mem_rdata;

  logic [AXI_WIDTH-1:0]    mem_model [0:255];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .AXI_WIDTH(AXI_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .WR_PRIORITY(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_rvalid(rd_rvalid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata)
  );

  ram_port_arbiter #(
    .AXI_WIDTH(AXI_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .WR_PRIORITY(1)
  ) u_pri (
    .clk(clk), .rst(rst),
    .rd_valid(p_rd_valid), .rd_addr(rd_addr), .rd_ready(p_rd_ready),
    .rd_data(p_rd_data), .rd_rvalid(p_rd_rvalid),
    .wr_valid(p_wr_valid), .wr_ready(p_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .mem_ren(p_mem_ren), .mem_wen(p_mem_wen), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_strb(p_mem_strb), .mem_rdata(p_mem_rdata)
  );

  function automatic logic [AXI_WIDTH-1:0] init_word(input int a);
    if (a == 16) return {16{8'hA5}};
    return {16{8'(a)}};
  endfunction

  // Synchronous RAM: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= init_word(i);
    end else begin
      if (mem_wen) begin
        for (int b = 0; b < SW; b++)
          if (mem_strb[b]) mem_model[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      if (mem_ren) mem_rdata <= mem_model[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [AXI_WIDTH-1:0] obs,
                       input logic [AXI_WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("excl", 128'(mem_ren & mem_wen), 128'd0);
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  int         seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [2:0] er;

  initial begin
    rst = 1'b1; rd_valid = 3'b111; wr_valid = 1'b1; rd_addr = '0;
    wr_addr = '0; wr_data = '0; wr_strb = '0;
    p_rd_valid = 3'b000; p_wr_valid = 1'b0; p_mem_rdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rd_ready", 128'(rd_ready), 128'd0);
    check("rst_wr_ready", 128'(wr_ready), 128'd0);
    check("rst_mem_ren",  128'(mem_ren), 128'd0);
    check("rst_mem_wen",  128'(mem_wen), 128'd0);
    check("rst_rvalid",   128'(rd_rvalid), 128'd0);
    check("rst_rd_data0", rd_data[0 +: 128], 128'd0);
    rst = 1'b0; rd_valid = 3'b000; wr_valid = 1'b0;
    tick();

    // single read from reader 0
    rd_valid = 3'b001; set_rd(0, 28'h10);
    #1;
    check("sr_ready", 128'(rd_ready), 128'd1);
    check("sr_ren",   128'(mem_ren), 128'd1);
    check("sr_addr",  128'(mem_addr), 128'h10);
    tick();
    rd_valid = 3'b000;
    #1;
    check("idle_ren",   128'(mem_ren), 128'd0);
    check("idle_addr",  128'(mem_addr), 128'd0);
    check("idle_wdata", mem_wdata, 128'd0);
    check("idle_strb",  128'(mem_strb), 128'd0);
    check("sr_rv_early", 128'(rd_rvalid), 128'd0);
    tick();
    #1;
    check("sr_rvalid", 128'(rd_rvalid), 128'b001);
    check("sr_data",   rd_data[0 +: 128], {16{8'hA5}});
    tick();

    // all four requesting: pointer sits at 1 after the reader-0 grant
    set_rd(0, 28'h01); set_rd(1, 28'h02); set_rd(2, 28'h03);
    wr_addr = 28'h40; wr_data = 128'hDEAD; wr_strb = '1;
    for (int c = 0; c < 10; c++) begin
      rd_valid = (c < 8) ? 3'b111 : 3'b000;
      wr_valid = (c < 8);
      #1;
      if (c < 8) check("rr_gnt", 128'({wr_ready, rd_ready}), 128'(4'b0001 << seq[c]));
      er = 3'b000;
      if (c >= 2 && seq[c-2] != 3) er = 3'(1 << seq[c-2]);
      check("rr_rvalid", 128'(rd_rvalid), 128'(er));
      if (er != 3'b000)
        check("rr_data", rd_data[seq[c-2]*128 +: 128], init_word(seq[c-2] + 1));
      tick();
    end

    // write 0x20, then reader 1 reads it back
    wr_valid = 1'b1; wr_addr = 28'h20; wr_data = 128'h00112233445566778899AABBCCDDEEFF;
    wr_strb = '1;
    #1;
    check("wr_ready", 128'({wr_ready, rd_ready}), 128'b1000);
    check("wr_wen",   128'({mem_wen, mem_ren}), 128'b10);
    check("wr_addr",  128'(mem_addr), 128'h20);
    check("wr_wdata", mem_wdata, 128'h00112233445566778899AABBCCDDEEFF);
    check("wr_strb",  128'(mem_strb), 128'hFFFF);
    tick();
    wr_valid = 1'b0; rd_valid = 3'b010; set_rd(1, 28'h20);
    #1;
    check("wrd_ready", 128'(rd_ready), 128'b010);
    tick();
    rd_valid = 3'b000;
    tick();
    check("wrd_rvalid", 128'(rd_rvalid), 128'b010);
    check("wrd_data",   rd_data[128 +: 128], 128'h00112233445566778899AABBCCDDEEFF);

    // partial write of the low 4 bytes, read back through reader 2
    wr_valid = 1'b1; wr_data = {16{8'hAB}}; wr_strb = 16'h000F;
    tick();
    wr_valid = 1'b0; rd_valid = 3'b100; set_rd(2, 28'h20);
    #1;
    check("pw_ready", 128'(rd_ready), 128'b100);
    tick();
    rd_valid = 3'b000;
    tick();
    check("pw_rvalid", 128'(rd_rvalid), 128'b100);
    check("pw_data",   rd_data[256 +: 128], 128'h00112233445566778899AABBABABABAB);
    check("hold_data", rd_data[128 +: 128], 128'h00112233445566778899AABBCCDDEEFF);
    tick();

    // reset lands while a read is in flight
    rd_valid = 3'b001; set_rd(0, 28'h05);
    #1;
    check("rm_ready", 128'(rd_ready), 128'b001);
    tick();
    rst = 1'b1; rd_valid = 3'b111; wr_valid = 1'b1;
    #1;
    check("rm_rst_ready", 128'({wr_ready, rd_ready}), 128'd0);
    check("rm_rst_mem",   128'({mem_wen, mem_ren}), 128'd0);
    tick();
    rst = 1'b0; rd_valid = 3'b110; wr_valid = 1'b0; set_rd(1, 28'h06);
    #1;
    check("rm_no_rvalid", 128'(rd_rvalid), 128'd0);
    check("rm_data_clr",  rd_data[0 +: 128], 128'd0);
    check("rm_first_gnt", 128'(rd_ready), 128'b010);
    tick();
    rd_valid = 3'b000;
    check("rm_no_rvalid2", 128'(rd_rvalid), 128'd0);
    tick();
    check("rm_rvalid", 128'(rd_rvalid), 128'b010);
    check("rm_data",   rd_data[128 +: 128], init_word(6));

    // writer-priority instance: five writes, then readers resume from 0
    rst = 1'b1;
    tick();
    rst = 1'b0; p_rd_valid = 3'b111; p_wr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("pri_wr", 128'({p_wr_ready, p_rd_ready}), 128'b1000);
      tick();
    end
    p_wr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("pri_rd", 128'(p_rd_ready), 128'(3'b001 << c));
      tick();
    end
    p_rd_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
